// File: rtl/shadow_compare_if.sv
// Bus bundle for the shadow-tracer lock-step comparator.
// The tracer/CPU side uses the master view; the comparator uses the slave view.
interface shadow_compare_if #(
  parameter int W     = 32,
  parameter int TS_W  = 32,
  parameter int CNT_W = 16
);
  logic             arm;
  logic             stop_on_fail;
  logic [W-1:0]     model_vec;
  logic [W-1:0]     target_vec;
  logic [W-1:0]     cmp_mask;
  logic             match;
  logic             fail;
  logic [CNT_W-1:0] mismatch_count;
  logic [TS_W-1:0]  cycle_count;
  logic [1:0]       state;
  logic             log_valid;
  logic             log_ready;
  logic [W-1:0]     log_diff;
  logic [TS_W-1:0]  log_ts;
  logic             log_overflow;

  modport master (
    output arm, stop_on_fail, model_vec, target_vec, cmp_mask, log_ready,
    input  match, fail, mismatch_count, cycle_count, state,
           log_valid, log_diff, log_ts, log_overflow
  );

  modport slave (
    input  arm, stop_on_fail, model_vec, target_vec, cmp_mask, log_ready,
    output match, fail, mismatch_count, cycle_count, state,
           log_valid, log_diff, log_ts, log_overflow
  );
endinterface

// File: rtl/shadow_compare.sv
// Lock-step comparator between the T80 shadow core and the real CPU pins.
// Aligns the model side by DELAY cycles, ignores a settle window after arm,
// keeps sticky/saturating mismatch statistics and logs every mismatch with
// its timestamp into a small show-ahead FIFO drained by the UART logic.
module shadow_compare #(
  parameter int W         = 32,
  parameter int DELAY     = 0,
  parameter int SETTLE    = 2,
  parameter int TS_W      = 32,
  parameter int CNT_W     = 16,
  parameter int LOG_DEPTH = 8
) (
  input logic             CLK_n,
  input logic             RESET,
  shadow_compare_if.slave bus
);

  localparam int AW = $clog2(LOG_DEPTH);
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [SW-1:0]    settleCnt_q, settleCnt_d;
  logic             match_q, match_d;
  logic             fail_q, fail_d;
  logic [CNT_W-1:0] mismatchCnt_q, mismatchCnt_d;
  logic [TS_W-1:0]  cycleCnt_q, cycleCnt_d;
  logic             overflow_q, overflow_d;
  logic [AW:0]      wrPtr_q, rdPtr_q;

  logic [W-1:0]     modelDly, maskDly, diff;
  logic             hit, push, pushAccept, pop, clearLog, logValid, logFull;

  logic [W-1:0]     diffMem [LOG_DEPTH];
  logic [TS_W-1:0]  tsMem   [LOG_DEPTH];

  generate
    if (DELAY == 0) begin : gNoDelay
      assign modelDly = bus.model_vec;
      assign maskDly  = bus.cmp_mask;
    end else begin : gDelay
      logic [W-1:0] modelPipe_q [DELAY];
      logic [W-1:0] maskPipe_q  [DELAY];

      // Shift model vector and mask so they line up with the later pin sample
      always_ff @(posedge CLK_n) begin
        if (RESET) begin
          for (int i = 0; i < DELAY; i++) begin
            modelPipe_q[i] <= '0;
            maskPipe_q[i]  <= '0;
          end
        end else begin
          modelPipe_q[0] <= bus.model_vec;
          maskPipe_q[0]  <= bus.cmp_mask;
          for (int i = 1; i < DELAY; i++) begin
            modelPipe_q[i] <= modelPipe_q[i-1];
            maskPipe_q[i]  <= maskPipe_q[i-1];
          end
        end
      end

      assign modelDly = modelPipe_q[DELAY-1];
      assign maskDly  = maskPipe_q[DELAY-1];
    end
  endgenerate

  assign diff     = (modelDly ^ bus.target_vec) & maskDly;
  assign hit      = |diff;
  assign logValid = (wrPtr_q != rdPtr_q);
  assign logFull  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                    (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign pop      = logValid && bus.log_ready;

  // Next-state, statistics and log-push decisions; arm overrides everything
  always_comb begin
    state_d       = state_q;
    settleCnt_d   = settleCnt_q;
    match_d       = match_q;
    fail_d        = fail_q;
    mismatchCnt_d = mismatchCnt_q;
    cycleCnt_d    = cycleCnt_q;
    overflow_d    = overflow_q;
    push          = 1'b0;
    clearLog      = 1'b0;

    if (bus.arm) begin
      state_d       = ST_SETTLE;
      settleCnt_d   = '0;
      match_d       = 1'b1;
      fail_d        = 1'b0;
      mismatchCnt_d = '0;
      cycleCnt_d    = '0;
      overflow_d    = 1'b0;
      clearLog      = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          match_d = 1'b1;
        end
        ST_SETTLE: begin
          match_d    = 1'b1;
          cycleCnt_d = cycleCnt_q + 1'b1;
          if (settleCnt_q == SW'(SETTLE - 1)) state_d = ST_RUN;
          else                                settleCnt_d = settleCnt_q + 1'b1;
        end
        ST_RUN: begin
          cycleCnt_d = cycleCnt_q + 1'b1;
          match_d    = ~hit;
          if (hit) begin
            fail_d = 1'b1;
            push   = 1'b1;
            if (mismatchCnt_q != '1) mismatchCnt_d = mismatchCnt_q + 1'b1;
            if (bus.stop_on_fail)    state_d = ST_STOP;
          end
        end
        default: begin
          match_d = 1'b0;
        end
      endcase
    end

    pushAccept = push && (!logFull || pop);
    if (push && logFull && !pop) overflow_d = 1'b1;
  end

  // State and statistics registers
  always_ff @(posedge CLK_n) begin
    if (RESET) begin
      state_q       <= ST_IDLE;
      settleCnt_q   <= '0;
      match_q       <= 1'b1;
      fail_q        <= 1'b0;
      mismatchCnt_q <= '0;
      cycleCnt_q    <= '0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      settleCnt_q   <= settleCnt_d;
      match_q       <= match_d;
      fail_q        <= fail_d;
      mismatchCnt_q <= mismatchCnt_d;
      cycleCnt_q    <= cycleCnt_d;
      overflow_q    <= overflow_d;
    end
  end

  // Log FIFO pointers; one extra bit distinguishes full from empty
  always_ff @(posedge CLK_n) begin
    if (RESET || clearLog) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      if (pop)        rdPtr_q <= rdPtr_q + 1'b1;
      if (pushAccept) wrPtr_q <= wrPtr_q + 1'b1;
    end
  end

  // Log storage; contents are only meaningful between the pointers
  always_ff @(posedge CLK_n) begin
    if (pushAccept) begin
      diffMem[wrPtr_q[AW-1:0]] <= diff;
      tsMem[wrPtr_q[AW-1:0]]   <= cycleCnt_q;
    end
  end

  assign bus.match          = match_q;
  assign bus.fail           = fail_q;
  assign bus.mismatch_count = mismatchCnt_q;
  assign bus.cycle_count    = cycleCnt_q;
  assign bus.state          = state_q;
  assign bus.log_valid      = logValid;
  assign bus.log_overflow   = overflow_q;
  assign bus.log_diff       = logValid ? diffMem[rdPtr_q[AW-1:0]] : '0;
  assign bus.log_ts         = logValid ? tsMem[rdPtr_q[AW-1:0]]   : '0;

endmodule
